// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================
// alu_pkg : shared opcode encodings, data width and operand bundle
// Rev 1.0
// ============================================================
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] ADD     = 4'h0;
   localparam logic [3:0] NEGA    = 4'h1;
   localparam logic [3:0] AND     = 4'h2;
   localparam logic [3:0] OR      = 4'h3;
   localparam logic [3:0] XOR     = 4'h4;
   localparam logic [3:0] INVA    = 4'h5;
   localparam logic [3:0] SELAB   = 4'h6;
   localparam logic [3:0] SELBA   = 4'h7;
   localparam logic [3:0] SUB     = 4'h8;
   localparam logic [3:0] ALTB    = 4'h9;
   localparam logic [3:0] ALTEB   = 4'hA;
   localparam logic [3:0] AGTB    = 4'hB;
   localparam logic [3:0] AGTEB   = 4'hC;
   localparam logic [3:0] AEQB    = 4'hD;
   localparam logic [3:0] ANEQB   = 4'hE;
   localparam logic [3:0] SELXORB = 4'hF;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [3:0]        inst;
      logic              sel;
   } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_fu_pipe_if.sv
`default_nettype none
// ============================================================
// alu_fu_pipe_if : issue/response handshake bundle for alu_fu_pipe
// Rev 1.0
// ============================================================
interface alu_fu_pipe_if #(
   parameter int TAG_W = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [alu_pkg::DATA_W-1:0] in_a;
   logic [alu_pkg::DATA_W-1:0] in_b;
   logic [3:0]                 in_inst;
   logic                       in_sel;
   logic [TAG_W-1:0]           in_tag;
   logic                       out_valid;
   logic                       out_ready;
   logic [alu_pkg::DATA_W-1:0] out_z;
   logic                       out_zero;
   logic                       out_ovf;
   logic [TAG_W-1:0]           out_tag;
   logic                       busy;

   modport master (
      output in_valid, in_a, in_b, in_inst, in_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_z, out_zero, out_ovf, out_tag, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_inst, in_sel, in_tag, out_ready,
      output in_ready, out_valid, out_z, out_zero, out_ovf, out_tag, busy
   );
endinterface
`default_nettype wire

// File: rtl/Alu.sv
`default_nettype none
// ============================================================
// Alu : combinational 32-bit ALU, 16 opcodes, signed compares
// Rev 1.0
// ============================================================
module Alu
   import alu_pkg::*;
(
   input  wire logic [DATA_W-1:0] a,
   input  wire logic [DATA_W-1:0] b,
   input  wire logic [3:0]        inst,
   input  wire logic              sel,
   output logic      [DATA_W-1:0] z
);
   logic lt;
   logic eq;

   assign lt = $signed(a) < $signed(b);
   assign eq = (a == b);

   // Compare opcodes return a single flag bit in Z[0]
   always_comb begin
      z = '0;
      case (inst)
         ADD:     z = a + b;
         NEGA:    z = '0 - a;
         AND:     z = a & b;
         OR:      z = a | b;
         XOR:     z = a ^ b;
         INVA:    z = ~a;
         SELAB:   z = sel ? b : a;
         SELBA:   z = sel ? a : b;
         SUB:     z = a - b;
         ALTB:    z = {{(DATA_W-1){1'b0}}, lt};
         ALTEB:   z = {{(DATA_W-1){1'b0}}, lt | eq};
         AGTB:    z = {{(DATA_W-1){1'b0}}, ~(lt | eq)};
         AGTEB:   z = {{(DATA_W-1){1'b0}}, ~lt};
         AEQB:    z = {{(DATA_W-1){1'b0}}, eq};
         ANEQB:   z = {{(DATA_W-1){1'b0}}, ~eq};
         SELXORB: z = {{(DATA_W-1){1'b0}}, sel ^ b[0]};
         default: z = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_fu_pipe.sv
`default_nettype none
// ============================================================
// alu_fu_pipe : two-stage valid/ready functional unit around Alu
// Rev 1.0
// ============================================================
module alu_fu_pipe
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  wire logic    clk,
   input  wire logic    rst,
   alu_fu_pipe_if.slave bus
);
   logic              s1_valid_q, s1_valid_d;
   alu_op_t           s1_op_q,    s1_op_d;
   logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_z_q,     s2_z_d;
   logic              s2_zero_q,  s2_zero_d;
   logic              s2_ovf_q,   s2_ovf_d;
   logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

   logic              s1_adv;
   logic              in_ready;
   logic              accept;
   logic              s2_load;
   logic [DATA_W-1:0] alu_z;
   logic              z_ovf;

   Alu alu_core (
      .a    (s1_op_q.a),
      .b    (s1_op_q.b),
      .inst (s1_op_q.inst),
      .sel  (s1_op_q.sel),
      .z    (alu_z)
   );

   always_comb begin
      z_ovf = 1'b0;
      case (s1_op_q.inst)
         ADD:     z_ovf = (s1_op_q.a[DATA_W-1] == s1_op_q.b[DATA_W-1]) &&
                          (alu_z[DATA_W-1] != s1_op_q.a[DATA_W-1]);
         SUB:     z_ovf = (s1_op_q.a[DATA_W-1] != s1_op_q.b[DATA_W-1]) &&
                          (alu_z[DATA_W-1] != s1_op_q.a[DATA_W-1]);
         NEGA:    z_ovf = (s1_op_q.a == {1'b1, {(DATA_W-1){1'b0}}});
         default: z_ovf = 1'b0;
      endcase
   end

   // in_ready is combinational through out_ready so a full pipe can drain and refill in one cycle
   assign s1_adv   = !s2_valid_q || bus.out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign accept   = bus.in_valid && in_ready;
   assign s2_load  = s1_valid_q && s1_adv;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_z_d     = s2_z_q;
      s2_zero_d  = s2_zero_q;
      s2_ovf_d   = s2_ovf_q;
      s2_tag_d   = s2_tag_q;

      if (accept) begin
         s1_valid_d   = 1'b1;
         s1_op_d.a    = bus.in_a;
         s1_op_d.b    = bus.in_b;
         s1_op_d.inst = bus.in_inst;
         s1_op_d.sel  = bus.in_sel;
         s1_tag_d     = bus.in_tag;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         s2_z_d     = alu_z;
         s2_zero_d  = (alu_z == '0);
         s2_ovf_d   = z_ovf;
         s2_tag_d   = s1_tag_q;
      end else if (bus.out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_z_q     <= '0;
         s2_zero_q  <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_z_q     <= s2_z_d;
         s2_zero_q  <= s2_zero_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_z     = s2_z_q;
   assign bus.out_zero  = s2_zero_q;
   assign bus.out_ovf   = s2_ovf_q;
   assign bus.out_tag   = s2_tag_q;
   assign bus.busy      = s1_valid_q || s2_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_fu_pipe.sv
`default_nettype none
// ============================================================
// tb_alu_fu_pipe : scoreboard bench for alu_fu_pipe
// Rev 1.0
// ============================================================
module tb_alu_fu_pipe;
   logic clk;
   logic rst;

   alu_fu_pipe_if #(.TAG_W(4)) bus ();

   alu_fu_pipe #(.TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [31:0] z;
      logic        zero;
      logic        ovf;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   bg_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_z(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] inst, input logic sel);
      logic signed [31:0] sa, sb_;
      sa = a; sb_ = b;
      case (inst)
         4'h0: return a + b;
         4'h1: return ~a + 32'd1;
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return ~a;
         4'h6: return sel ? b : a;
         4'h7: return sel ? a : b;
         4'h8: return a + ~b + 32'd1;
         4'h9: return (sa <  sb_) ? 32'd1 : 32'd0;
         4'hA: return (sa <= sb_) ? 32'd1 : 32'd0;
         4'hB: return (sa >  sb_) ? 32'd1 : 32'd0;
         4'hC: return (sa >= sb_) ? 32'd1 : 32'd0;
         4'hD: return (a == b)    ? 32'd1 : 32'd0;
         4'hE: return (a != b)    ? 32'd1 : 32'd0;
         default: return {31'd0, sel ^ b[0]};
      endcase
   endfunction

   function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b, input logic [3:0] inst);
      logic [32:0] s;
      case (inst)
         4'h0: begin s = {a[31], a} + {b[31], b}; return s[32] ^ s[31]; end
         4'h8: begin s = {a[31], a} - {b[31], b}; return s[32] ^ s[31]; end
         4'h1: return a == 32'h8000_0000;
         default: return 1'b0;
      endcase
   endfunction

   // Offer one request; push its expected result when the handshake completes
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] inst,
                        input logic sel, input logic [3:0] tag, input logic [31:0] ez,
                        input logic ezero, input logic eovf, input bit need_first);
      exp_t e;
      bit   ok;
      int   waits;
      e.z = ez; e.zero = ezero; e.ovf = eovf; e.tag = tag;
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
      bus.in_inst = inst;  bus.in_sel = sel; bus.in_tag = tag;
      ok = 1'b0; waits = 0;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(e);
            ok = 1'b1;
            waits = w;
            break;
         end
      end
      if (ok) begin
         @(posedge clk); #1;
      end else begin
         chk("issue_timeout", 32'd0, 32'd1);
      end
      bus.in_valid = 1'b0;
      if (need_first) chk("in_ready_stream", waits, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_tag", {28'd0, bus.out_tag}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_z",    bus.out_z,             e.z);
            chk("out_zero", {31'd0, bus.out_zero}, {31'd0, e.zero});
            chk("out_ovf",  {31'd0, bus.out_ovf},  {31'd0, e.ovf});
            chk("out_tag",  {28'd0, bus.out_tag},  {28'd0, e.tag});
         end
      end
   end

   initial begin
      logic [31:0] ra, rb, held_z;
      logic [3:0]  ri;
      logic        rs;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_inst = '0;
      bus.in_sel = 1'b0;   bus.in_tag = '0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_z",     bus.out_z, 32'd0);
      chk("rst_out_zero",  {31'd0, bus.out_zero}, 32'd0);
      chk("rst_out_ovf",   {31'd0, bus.out_ovf}, 32'd0);
      chk("rst_out_tag",   {28'd0, bus.out_tag}, 32'd0);
      chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;

      // Directed vectors with hand-computed results
      bus.out_ready = 1'b1;
      issue(32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 1'b0, 4'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      issue(32'h0000_0005, 32'h0000_0005, 4'h8, 1'b0, 4'd4, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h0000_0000, 4'h1, 1'b0, 4'd5, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      issue(32'hFFFF_FFFF, 32'h0000_0001, 4'h9, 1'b0, 4'd6, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      issue(32'h0000_0000, 32'h0000_0001, 4'hF, 1'b1, 4'd7, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 4'h8, 1'b0, 4'd8, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
      issue(32'h1234_5678, 32'h1234_5678, 4'hD, 1'b0, 4'd9, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk); #1;

      // Backpressure: two accepts fill the pipe, the third request must stall
      bus.out_ready = 1'b0;
      issue(32'h0000_0001, 32'h0000_0002, 4'h0, 1'b0, 4'd1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'h2, 1'b0, 4'd2, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      bg_done = 1'b0;
      fork
         begin
            issue(32'h0000_0000, 32'h0000_0000, 4'h5, 1'b0, 4'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
            bg_done = 1'b1;
         end
      join_none
      @(negedge clk);
      held_z = bus.out_z;
      chk("bp_held_z_first", held_z, 32'h0000_0003);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_held_tag",     {28'd0, bus.out_tag}, 32'd1);
         chk("bp_held_z",       bus.out_z, held_z);
         chk("bp_out_valid",    {31'd0, bus.out_valid}, 32'd1);
         @(negedge clk);
      end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && !bg_done; i++) @(posedge clk);
      chk("bp_third_accepted", {31'd0, bg_done}, 32'd1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("bp_drained", sb.size(), 0);
      @(posedge clk); #1;

      // Continuous stream: every op must be accepted on its first offer
      for (int i = 0; i < 16; i++) begin
         ra = $urandom; rb = $urandom;
         if (i == 3) rb = ra;
         ri = 4'($urandom_range(0, 15)); rs = 1'($urandom_range(0, 1));
         issue(ra, rb, ri, rs, 4'(i), model_z(ra, rb, ri, rs),
               model_z(ra, rb, ri, rs) == 32'd0, model_ovf(ra, rb, ri), i != 0);
      end
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("stream_drained", sb.size(), 0);
      @(posedge clk); #1;

      // Reset with two ops in flight discards them
      bus.out_ready = 1'b0;
      issue(32'h0000_0010, 32'h0000_0020, 4'h0, 1'b0, 4'd10, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
      issue(32'h0000_0010, 32'h0000_0020, 4'h3, 1'b0, 4'd11, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_mid_busy",      {31'd0, bus.busy}, 32'd0);
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale_out", {31'd0, bus.out_valid}, 32'd0);
      end
      chk("post_rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/alu_fu_pipe.md
# alu_fu_pipe

Pipelined issue/response wrapper around the combinational `Alu`, making it a handshaked functional unit. It accepts one operation per cycle from an upstream issue stage over a valid/ready interface. It returns the 32-bit result with zero/overflow flags and a caller-supplied tag two cycles later. It sits between the instruction issue logic and writeback, and is the consumer-side counterpart of the stimulus driver that exercises `Alu`.

## Interface
- TAG_W, 4, width of the opaque request tag echoed with the result
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_a  in  32  operand A (two's complement)
- in_b  in  32  operand B (two's complement)
- in_inst  in  4  opcode, same encoding as `Alu` INST
- in_sel  in  1  select bit for opcodes 6, 7, 15
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_z  out  32  result
- out_zero  out  1  out_z == 0
- out_ovf  out  1  signed overflow (see Operation)
- out_tag  out  TAG_W  tag of this result
- busy  out  1  either stage holds a valid op

## Operation
- Opcodes: 0 ADD, 1 NEGA, 2 AND, 3 OR, 4 XOR, 5 INVA, 6 SELAB, 7 SELBA, 8 SUB, 9 A<B, A A<=B, B A>B, C A>=B, D A==B, E A!=B, F SEL^B[0].
  - Opcodes 9–F: Z = {31'b0, bit}.
  - Comparisons are signed.
- Stage 1 (S1): input register capturing a, b, inst, sel, tag on in_valid && in_ready.
- Stage 2 (S2): output register capturing `Alu` Z from the S1 operands, plus flags and tag.
- Handshake:
  - s1_adv = !s2_valid || out_ready
  - in_ready = !s1_valid || s1_adv
  - S2 loads when s1_valid && s1_adv.
  - s2_valid clears when out_ready && !(s1_valid && s1_adv).
- out_z, out_zero, out_ovf, out_tag are registered and hold stable while out_valid && !out_ready.
- Overflow is computed in S1 from the S1 operands and Z; it is 0 for all other opcodes:
  - ADD: A[31]==B[31] && Z[31]!=A[31]
  - SUB: A[31]!=B[31] && Z[31]!=A[31]
  - NEGA: A == 32'h8000_0000
- All arithmetic is 32-bit modulo 2^32. Carry-out is discarded.
- busy = s1_valid || s2_valid.

## Timing
- Reset (async assert, sync release): s1_valid = s2_valid = 0; out_z = 0; out_zero = 0; out_ovf = 0; out_tag = 0; in_ready = 1 one cycle after release; busy = 0.
- Latency: request accepted at edge N appears on out_valid after edge N+1, i.e. 2 cycles. Throughput is 1/cycle with out_ready held high.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. No request is dropped or overwritten.
- Simultaneous drain and accept with both stages full and out_ready = 1:
  - S2 takes S1.
  - S1 takes the new request.
  - in_ready stays 1 (combinational through out_ready).
- Reset mid-operation discards both stages. No result is emitted for in-flight tags.
- in_* are ignored when !in_valid. out_ready is ignored when !out_valid.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams: ADD, NEGA, AND, OR, XOR, INVA, SELAB, SELBA, SUB, ALTB, ALTEB, AGTB, AGTEB, AEQB, ANEQB, SELXORB
  - data width constant 32
- One sub-module: existing `Alu` instance `alu_core`, driven from S1 registers.
- Overflow and zero logic, pipeline registers, and handshake live in `alu_fu_pipe`.

## Test plan
- ADD 7FFF_FFFF + 0000_0001, tag 3 -> after 2 cycles: Z = 8000_0000, ovf = 1, zero = 0, tag = 3.
- SUB 0000_0005 - 0000_0005, then NEGA 8000_0000 back-to-back, out_ready = 1 -> consecutive cycles:
  - Z = 0, zero = 1, ovf = 0
  - Z = 8000_0000, ovf = 1
- Signed compare ALTB A = FFFF_FFFF, B = 0000_0001 -> Z = 0000_0001. SELXORB SEL = 1, B = 0000_0001 -> Z = 0.
- Backpressure:
  - Issue tags 1, 2, 3 with out_ready = 0 -> in_ready drops after 2 accepts; tag 1 is held stable on out_*.
  - Raise out_ready -> tags 1, 2, 3 emerge in order with no loss or duplication.
- Full pipe with out_ready = 1 and in_valid = 1 every cycle for 16 random ops -> in_ready stays 1 and every result matches the reference model.
- Assert rst with two ops in flight -> out_valid = 0 and busy = 0 immediately. After release, no stale result appears and in_ready = 1.
